// File: rtl/aux_input_ctrl.sv
// aux_input_ctrl: button synchronizer/debouncer, press-edge detection and a
// PAUSE/RUN/HALT controller that emits the registered core advance enable.
module aux_input_ctrl #(
  parameter int DebounceCntMax = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_run,
  input  logic       btn_step,
  input  logic       tick,
  input  logic       fast,
  input  logic       halt,
  output logic       en,
  output logic [1:0] state,
  output logic       running
);

  localparam int CntW = (DebounceCntMax > 1) ? $clog2(DebounceCntMax) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCntMax - 1);

  typedef enum logic [1:0] {
    ST_PAUSE = 2'b00,
    ST_RUN   = 2'b01,
    ST_HALT  = 2'b10,
    ST_BAD   = 2'b11
  } state_e;

  // Bit 0 carries the run button, bit 1 the step button throughout.
  logic [1:0]      w_btn;
  logic [1:0]      r_sync1;
  logic [1:0]      r_sync2;
  logic [1:0]      r_db;
  logic [1:0]      r_db_q;
  logic [1:0]      r_press;
  logic [CntW-1:0] r_cnt [2];

  logic            r_halt;
  state_e          r_state;
  state_e          w_state_next;
  logic            w_en_next;
  logic            r_en;
  logic            r_running;

  logic            w_run_press;
  logic            w_step_press;
  logic            w_tk;

  assign w_btn        = {btn_step, btn_run};
  assign w_run_press  = r_press[0];
  assign w_step_press = r_press[1];
  assign w_tk         = fast | tick;

  // Two-flop synchronizer, per-button debounce counter and rising-edge press pulse.
  // NOTE: every register here, including the counter array, is reset so a
  // partially counted debounce is discarded the moment rst_n drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_q  <= '0;
      r_press <= '0;
      for (int i = 0; i < 2; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value, which is what gives the chain its one-cycle-per-stage latency.
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_db_q  <= r_db;
      r_press <= r_db & ~r_db_q;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CntLast) begin
          r_db[i]  <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Next state and next advance enable; halt is taken from its registered copy.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a value unassigned
    // (which would infer a latch).
    w_state_next = r_state;
    w_en_next    = 1'b0;
    case (r_state)
      ST_PAUSE: begin
        if (r_halt) begin
          w_state_next = ST_HALT;
        end else if (w_run_press) begin
          w_state_next = ST_RUN;
        end else if (w_step_press) begin
          w_en_next = 1'b1;
        end
      end
      ST_RUN: begin
        if (r_halt) begin
          w_state_next = ST_HALT;
        end else if (w_run_press) begin
          w_state_next = ST_PAUSE;
        end else begin
          w_en_next = w_tk;
        end
      end
      ST_HALT: begin
        w_state_next = ST_HALT;
      end
      default: begin
        w_state_next = ST_PAUSE;
      end
    endcase
  end

  // State register plus registered en/running outputs and halt capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_PAUSE;
      r_en      <= 1'b0;
      r_running <= 1'b0;
      r_halt    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_en      <= w_en_next;
      r_running <= (w_state_next == ST_RUN);
      r_halt    <= halt;
    end
  end

  assign en      = r_en;
  assign state   = r_state;
  assign running = r_running;

endmodule
